pipeline_sync_controller: RTL

//  Parametrised successor to the multicycle phase sequencer of the SimpleRISC core.

---
 rtl/pipeline_sync_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipeline_sync_controller.sv
// pipeline_sync_controller: per-stage load enables and valid bits for an N-stage pipeline,
//   with load-use stall, branch flush, halt/drain/resume and an integrated clock-enable divider.
// Ports: clk/rst (async active-low); stall/flush/halt/resume requests; tick (divided strobe);
//   stage_en (comb), stage_valid (reg), updatePC, halted, cycle_count, retired_count.
module pipeline_sync_controller #(
  parameter int STAGES      = 5,
  parameter int DIV         = 1,
  parameter int STALL_STAGE = 1,
  parameter int FLUSH_STAGE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              halt,
  input  logic              resume,
  output logic              tick,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_valid,
  output logic              updatePC,
  output logic              halted,
  output logic [31:0]       cycle_count,
  output logic [31:0]       retired_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0]     div_q, div_d;
  state_t            state_q, state_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       retired_q, retired_d;
  logic              div_wrap;
  logic              active;

  // Divider free-runs; tick is forced low while reset is asserted so every
  // output reads 0 in reset even when DIV=1.
  assign div_wrap = (div_q == DIV_LAST);
  assign tick     = rst & div_wrap;
  assign active   = tick & ((state_q == S_RUN) | (state_q == S_DRAIN));

  always_comb begin
    div_d = div_wrap ? '0 : div_q + 1'b1;
  end

  // State register plus all other flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      state_q   <= S_IDLE;
      valid_q   <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_IDLE:   state_d = S_RUN;
        S_RUN:    if (halt) state_d = S_DRAIN;
        S_DRAIN:  if (valid_q == '0) state_d = S_HALTED;
        S_HALTED: if (resume) state_d = S_RUN;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: enables and PC load
  always_comb begin
    stage_en = '0;
    updatePC = 1'b0;
    if (active) begin
      stage_en = '1;
      updatePC = (state_q == S_RUN);
      // Draining fetches nothing, so IF stays closed unless a flush reloads it.
      if (state_q == S_DRAIN) stage_en[0] = 1'b0;
      if (flush) begin
        stage_en[FLUSH_STAGE-1:0] = '1;
        updatePC = 1'b1;
      end else if (stall) begin
        stage_en[STALL_STAGE:0] = '0;
        updatePC = 1'b0;
      end
    end
  end

  // Valid bits shift one stage per active tick; flush wins over stall.
  always_comb begin
    valid_d = valid_q;
    if (active) begin
      valid_d = {valid_q[STAGES-2:0], (state_q == S_RUN)};
      if (flush) begin
        valid_d[FLUSH_STAGE-1:0] = '0;
      end else if (stall) begin
        valid_d[STALL_STAGE:0]   = valid_q[STALL_STAGE:0];
        valid_d[STALL_STAGE+1]   = 1'b0;
      end
    end
  end

  always_comb begin
    cycle_d   = cycle_q;
    retired_d = retired_q;
    if (tick && (state_q != S_HALTED)) cycle_d = cycle_q + 32'd1;
    if (tick && valid_q[STAGES-1] && stage_en[STAGES-1]) retired_d = retired_q + 32'd1;
  end

  assign stage_valid   = valid_q;
  assign halted        = (state_q == S_HALTED);
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule
